// File: rtl/cmplx_mixer_pkg.sv
// Shared width arithmetic and output helpers for the complex mixer pipeline.
package cmplx_mixer_pkg;

  function automatic int prod_w(input int idat_w, input int dds_w);
    return idat_w + dds_w;
  endfunction

  function automatic int sum_w(input int idat_w, input int dds_w);
    return idat_w + dds_w + 1;
  endfunction

  // LSBs removed from each product when only the mul_w MSBs are kept.
  function automatic int drop_w(input int idat_w, input int dds_w, input int mul_w);
    return (mul_w > 0 && mul_w < idat_w + dds_w) ? idat_w + dds_w - mul_w : 0;
  endfunction

  function automatic int shift_w(input int idat_w, input int dds_w, input int mul_w);
    int sh;
    sh = dds_w - 2 - drop_w(idat_w, dds_w, mul_w);
    return (sh < 0) ? 0 : sh;
  endfunction

  function automatic logic [63:0] round_const(input int sh, input bit use_round);
    return (use_round && sh > 0) ? (64'd1 << (sh - 1)) : 64'd0;
  endfunction

  // Keeps the low w bits and sign-extends from bit w-1 (wrap, no saturation).
  function automatic logic signed [63:0] fit_odat(input logic signed [63:0] v, input int w);
    logic signed [63:0] t;
    t = v <<< (64 - w);
    return t >>> (64 - w);
  endfunction

endpackage

// File: rtl/cmplx_mixer_mac.sv
// Registered a*b +/- c*d with an optional sum register inside the adder.
module cmplx_mixer_mac
  import cmplx_mixer_pkg::*;
#(
  parameter int pA_W         = 16,
  parameter int pB_W         = 17,
  parameter int pMUL_W       = 0,
  parameter bit pSUB         = 1'b0,
  parameter int pUSE_DSP_ADD = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clkena,
  input  logic signed [pA_W-1:0]      a,
  input  logic signed [pB_W-1:0]      b,
  input  logic signed [pA_W-1:0]      c,
  input  logic signed [pB_W-1:0]      d,
  output logic signed [pA_W+pB_W:0]   sum
);

  localparam int P    = prod_w(pA_W, pB_W);
  localparam int S    = sum_w(pA_W, pB_W);
  localparam int DROP = drop_w(pA_W, pB_W, pMUL_W);

  logic signed [P-1:0] prod_ab;
  logic signed [P-1:0] prod_cd;
  logic signed [P-1:0] trim_ab;
  logic signed [P-1:0] trim_cd;
  logic signed [S-1:0] sum_c;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prod_ab <= '0;
      prod_cd <= '0;
    end else if (clkena) begin
      prod_ab <= $signed({{pB_W{a[pA_W-1]}}, a}) * $signed({{pA_W{b[pB_W-1]}}, b});
      prod_cd <= $signed({{pB_W{c[pA_W-1]}}, c}) * $signed({{pA_W{d[pB_W-1]}}, d});
    end
  end

  // Truncated products keep their scale shift; the top shift is reduced to match.
  always_comb begin
    trim_ab = prod_ab >>> DROP;
    trim_cd = prod_cd >>> DROP;
    if (pSUB)
      sum_c = $signed({trim_ab[P-1], trim_ab}) - $signed({trim_cd[P-1], trim_cd});
    else
      sum_c = $signed({trim_ab[P-1], trim_ab}) + $signed({trim_cd[P-1], trim_cd});
  end

  if (pUSE_DSP_ADD != 0) begin : g_sum_reg
    logic signed [S-1:0] sum_q;
    always_ff @(posedge clk) begin
      if (!reset_n)
        sum_q <= '0;
      else if (clkena)
        sum_q <= sum_c;
    end
    assign sum = sum_q;
  end else begin : g_sum_comb
    assign sum = sum_c;
  end

endmodule

// File: rtl/cmplx_mixer.sv
// Pipelined complex multiply by a (optionally conjugated) phasor with unity-gain
// rescale, optional rounding and a valid shift chain matching the data latency.
module cmplx_mixer
  import cmplx_mixer_pkg::*;
#(
  parameter int pIDAT_W      = 16,
  parameter int pDDS_W       = 17,
  parameter int pODAT_W      = 18,
  parameter int pMUL_W       = 0,
  parameter int pCONJ        = 0,
  parameter int pUSE_DSP_ADD = 1,
  parameter int pUSE_ROUND   = 0
) (
  input  logic                       iclk,
  input  logic                       ireset,
  input  logic                       iclkena,
  input  logic                       ival,
  input  logic signed [pIDAT_W-1:0]  idat_re,
  input  logic signed [pIDAT_W-1:0]  idat_im,
  input  logic signed [pDDS_W-1:0]   icos,
  input  logic signed [pDDS_W-1:0]   isin,
  output logic                       oval,
  output logic signed [pODAT_W-1:0]  odat_re,
  output logic signed [pODAT_W-1:0]  odat_im
);

  localparam int S   = sum_w(pIDAT_W, pDDS_W);
  localparam int SH  = shift_w(pIDAT_W, pDDS_W, pMUL_W);
  localparam int LAT = (pUSE_DSP_ADD != 0) ? 4 : 3;
  localparam logic [63:0] RND = round_const(SH, pUSE_ROUND != 0);

  logic signed [pIDAT_W-1:0] re_q, im_q;
  logic signed [pDDS_W-1:0]  cos_q, sin_q;
  logic [LAT-1:0]            vld;

  always_ff @(posedge iclk) begin
    if (!ireset) begin
      re_q  <= '0;
      im_q  <= '0;
      cos_q <= '0;
      sin_q <= '0;
      vld   <= '0;
    end else if (iclkena) begin
      re_q  <= idat_re;
      im_q  <= idat_im;
      cos_q <= icos;
      sin_q <= isin;
      vld   <= {vld[LAT-2:0], ival};
    end
  end

  assign oval = vld[LAT-1];

  // Conjugation swaps the im-path operands so the subtract lands on re*sin.
  logic signed [pIDAT_W-1:0] im_a, im_c;
  logic signed [pDDS_W-1:0]  im_b, im_d;
  logic signed [S-1:0]       sum_re, sum_im;

  assign im_a = (pCONJ != 0) ? im_q  : re_q;
  assign im_b = (pCONJ != 0) ? cos_q : sin_q;
  assign im_c = (pCONJ != 0) ? re_q  : im_q;
  assign im_d = (pCONJ != 0) ? sin_q : cos_q;

  cmplx_mixer_mac #(
    .pA_W(pIDAT_W), .pB_W(pDDS_W), .pMUL_W(pMUL_W),
    .pSUB(pCONJ == 0), .pUSE_DSP_ADD(pUSE_DSP_ADD)
  ) u_mac_re (
    .clk(iclk), .reset_n(ireset), .clkena(iclkena),
    .a(re_q), .b(cos_q), .c(im_q), .d(sin_q), .sum(sum_re)
  );

  cmplx_mixer_mac #(
    .pA_W(pIDAT_W), .pB_W(pDDS_W), .pMUL_W(pMUL_W),
    .pSUB(pCONJ != 0), .pUSE_DSP_ADD(pUSE_DSP_ADD)
  ) u_mac_im (
    .clk(iclk), .reset_n(ireset), .clkena(iclkena),
    .a(im_a), .b(im_b), .c(im_c), .d(im_d), .sum(sum_im)
  );

  logic signed [S:0]         rnd_re, rnd_im;
  logic signed [S:0]         shr_re, shr_im;
  logic signed [63:0]        wide_re, wide_im;
  logic signed [pODAT_W-1:0] out_re, out_im;

  always_comb begin
    rnd_re  = $signed({sum_re[S-1], sum_re}) + $signed(RND[S:0]);
    rnd_im  = $signed({sum_im[S-1], sum_im}) + $signed(RND[S:0]);
    shr_re  = rnd_re >>> SH;
    shr_im  = rnd_im >>> SH;
    wide_re = {{(63-S){shr_re[S]}}, shr_re};
    wide_im = {{(63-S){shr_im[S]}}, shr_im};
    out_re  = pODAT_W'(fit_odat(wide_re, pODAT_W));
    out_im  = pODAT_W'(fit_odat(wide_im, pODAT_W));
  end

  // Output register only loads for valid samples so odat holds between them.
  always_ff @(posedge iclk) begin
    if (!ireset) begin
      odat_re <= '0;
      odat_im <= '0;
    end else if (iclkena && vld[LAT-2]) begin
      odat_re <= out_re;
      odat_im <= out_im;
    end
  end

endmodule

// File: tb/tb_cmplx_mixer.sv
// Bench for cmplx_mixer: a default instance and a conj/round/16-bit/latency-3
// instance share one stimulus stream and are checked against a delay-line model.
module tb_cmplx_mixer;

  logic iclk = 1'b0;
  logic ireset = 1'b0;
  logic iclkena = 1'b0;
  logic ival = 1'b0;
  logic signed [15:0] idat_re = '0, idat_im = '0;
  logic signed [16:0] icos = '0, isin = '0;

  logic               oval_a, oval_b;
  logic signed [17:0] odat_re_a, odat_im_a;
  logic signed [15:0] odat_re_b, odat_im_b;

  int checks = 0;
  int errors = 0;

  always #5 iclk = ~iclk;

  cmplx_mixer dut_a (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival),
    .idat_re(idat_re), .idat_im(idat_im), .icos(icos), .isin(isin),
    .oval(oval_a), .odat_re(odat_re_a), .odat_im(odat_im_a)
  );

  cmplx_mixer #(
    .pODAT_W(16), .pCONJ(1), .pUSE_DSP_ADD(0), .pUSE_ROUND(1)
  ) dut_b (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival),
    .idat_re(idat_re), .idat_im(idat_im), .icos(icos), .isin(isin),
    .oval(oval_b), .odat_re(odat_re_b), .odat_im(odat_im_b)
  );

  typedef struct { bit v; longint re; longint im; } slot_t;

  slot_t  q_a[$], q_b[$];
  bit     exp_va, exp_vb;
  longint held_re_a, held_im_a, held_re_b, held_im_b;

  // Unity gain is 2^15 for a 17-bit phasor, so the rescale is a shift by 15.
  function automatic longint wrap_to(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = v & (m - 1);
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  task automatic mix(input longint re, input longint im, input longint c, input longint s,
                     input bit conj, input bit rnd, input int w,
                     output longint ore, output longint oim);
    longint sre, sim;
    sre = conj ? re * c + im * s : re * c - im * s;
    sim = conj ? im * c - re * s : re * s + im * c;
    if (rnd) begin
      sre = sre + 16384;
      sim = sim + 16384;
    end
    ore = wrap_to(sre >>> 15, w);
    oim = wrap_to(sim >>> 15, w);
  endtask

  task automatic reset_model();
    slot_t z;
    z = '{v: 1'b0, re: 0, im: 0};
    q_a = {};
    q_b = {};
    repeat (3) q_a.push_back(z);
    repeat (2) q_b.push_back(z);
    exp_va = 1'b0;
    exp_vb = 1'b0;
    held_re_a = 0; held_im_a = 0; held_re_b = 0; held_im_b = 0;
  endtask

  task automatic check_bit(input string tag, input logic act, input bit exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, act, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic signed [63:0] act, input longint exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic checkOutput();
    check_bit("oval_a", oval_a, exp_va);
    check_val("odat_re_a", odat_re_a, held_re_a);
    check_val("odat_im_a", odat_im_a, held_im_a);
    check_bit("oval_b", oval_b, exp_vb);
    check_val("odat_re_b", odat_re_b, held_re_b);
    check_val("odat_im_b", odat_im_b, held_im_b);
  endtask

  task automatic applyStimulus(input bit en, input bit rst_n, input bit v,
                               input longint re, input longint im,
                               input longint c, input longint s);
    slot_t na, nb, oa, ob;
    @(negedge iclk);
    iclkena = en;
    ireset  = rst_n;
    ival    = v;
    idat_re = 16'(re);
    idat_im = 16'(im);
    icos    = 17'(c);
    isin    = 17'(s);
    @(posedge iclk);
    if (!rst_n) begin
      reset_model();
    end else if (en) begin
      na.v = v;
      nb.v = v;
      mix(re, im, c, s, 1'b0, 1'b0, 18, na.re, na.im);
      mix(re, im, c, s, 1'b1, 1'b1, 16, nb.re, nb.im);
      q_a.push_back(na);
      q_b.push_back(nb);
      oa = q_a.pop_front();
      ob = q_b.pop_front();
      exp_va = oa.v;
      exp_vb = ob.v;
      if (oa.v) begin held_re_a = oa.re; held_im_a = oa.im; end
      if (ob.v) begin held_re_b = ob.re; held_im_b = ob.im; end
    end
    #1 checkOutput();
  endtask

  task automatic rand_step(input bit en, input bit v, input bit rst_n);
    logic signed [15:0] r_re, r_im;
    logic signed [16:0] r_c, r_s;
    r_re = 16'($urandom);
    r_im = 16'($urandom);
    r_c  = 17'($urandom);
    r_s  = 17'($urandom);
    applyStimulus(en, rst_n, v, longint'(r_re), longint'(r_im), longint'(r_c), longint'(r_s));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_model();
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    idle(1);

    // Directed points: unity, 90 degrees, rounding threshold, extremes.
    applyStimulus(1'b1, 1'b1, 1'b1, 1000, -500, 32768, 0);
    idle(5);
    applyStimulus(1'b1, 1'b1, 1'b1, 1000, -500, 0, 32768);
    idle(5);
    applyStimulus(1'b1, 1'b1, 1'b1, 1, 0, 16384, 0);
    idle(5);
    applyStimulus(1'b1, 1'b1, 1'b1, -32768, -32768, 32768, 32768);
    idle(5);

    // Eight back-to-back samples with the enable dropped for two cycles.
    for (int i = 0; i < 10; i++) rand_step(i != 4 && i != 5, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(i % 3 != 1, 1'b1, 1'b0, 0, 0, 0, 0);

    // Reset while samples are in flight; nothing stale may emerge.
    for (int i = 0; i < 3; i++) rand_step(1'b1, 1'b1, 1'b1);
    rand_step(1'b1, 1'b1, 1'b0);
    idle(6);

    for (int i = 0; i < 80; i++)
      rand_step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 1'b1);
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
